mul_arbiter: RTL and testbench

- Shares one iterative signed 16x16 multiplier datapath between two requesters.
- Round-robin arbitration, valid/ready request handshake, one-cycle response pulse tagged with the requester id.
- Sits between two client blocks (e.g. ALU issue and address-gen) and replaces their private combinational multipliers.
- Datapath is radix-2 shift-add with a two's-complement final-step correction, internal to this block.

---
 rtl/mul_arbiter.sv | 114 +++++++++++
 tb/tb_mul_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester front end for one shared iterative signed WIDTH x WIDTH multiplier.
// Round-robin grant in IDLE, WIDTH shift-add cycles in CALC, one DONE cycle, then a response pulse.
module mul_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid_i,
    output logic                        req0_ready_o,
    input  logic signed [WIDTH-1:0]     A0_i,
    input  logic signed [WIDTH-1:0]     B0_i,
    input  logic                        req1_valid_i,
    output logic                        req1_ready_o,
    input  logic signed [WIDTH-1:0]     A1_i,
    input  logic signed [WIDTH-1:0]     B1_i,
    output logic signed [2*WIDTH-1:0]   C_o,
    output logic                        rsp_valid_o,
    output logic                        rsp_id_o,
    output logic                        busy_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic                        last_grant;
    logic [CNT_W-1:0]            cnt;
    logic signed [WIDTH-1:0]     op_a_p0;
    logic signed [WIDTH-1:0]     op_b_p0;
    logic                        id_p0;
    logic signed [2*WIDTH-1:0]   acc_p0;
    logic                        grant_id;
    logic                        accept;

    // One radix-2 step: add a*2^idx when multiplier bit idx is set; the top bit
    // carries negative weight, so its partial product is subtracted instead.
    function automatic logic signed [2*WIDTH-1:0] acc_step(
        input logic signed [2*WIDTH-1:0] acc,
        input logic signed [WIDTH-1:0]   a,
        input logic signed [WIDTH-1:0]   b,
        input logic [CNT_W-1:0]          idx
    );
        logic signed [2*WIDTH-1:0] term;
        term = {{WIDTH{a[WIDTH-1]}}, a};
        term = term <<< idx;
        if (!b[idx])
            return acc;
        else if (idx == LAST_BIT)
            return acc - term;
        else
            return acc + term;
    endfunction

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid_i && req1_valid_i)
            grant_id = ~last_grant;
        else if (req1_valid_i)
            grant_id = 1'b1;
    end

    assign req0_ready_o = (state == IDLE) && req0_valid_i && !grant_id;
    assign req1_ready_o = (state == IDLE) && req1_valid_i && grant_id;
    assign accept       = req0_ready_o || req1_ready_o;
    assign busy_o       = (state == CALC) || (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            C_o         <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            cnt         <= '0;
            last_grant  <= 1'b1;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                // Stage p0: operand capture on the accept edge
                IDLE: begin
                    if (accept) begin
                        op_a_p0    <= grant_id ? A1_i : A0_i;
                        op_b_p0    <= grant_id ? B1_i : B0_i;
                        id_p0      <= grant_id;
                        last_grant <= grant_id;
                        acc_p0     <= '0;
                        cnt        <= '0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc_p0 <= acc_step(acc_p0, op_a_p0, op_b_p0, cnt);
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT)
                        state <= DONE;
                end
                // Stage p1: publish the finished product as a one-cycle pulse
                DONE: begin
                    C_o         <= acc_p0;
                    rsp_id_o    <= id_p0;
                    rsp_valid_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed + randomized bench for mul_arbiter; products come from plain integer multiplication.
module tb_mul_arbiter;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic signed [15:0] A0, B0, A1, B1;
    logic [31:0]        C;
    logic               rsp_valid, rsp_id, busy;

    int checks = 0;
    int errors = 0;
    bit model_last;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .A0_i(A0), .B0_i(B0),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .A1_i(A1), .B1_i(B1),
        .C_o(C), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .busy_o(busy)
    );

    function automatic logic [31:0] ref_mul(input logic signed [15:0] a, input logic signed [15:0] b);
        int pa, pb;
        pa = a;
        pb = b;
        return 32'(pa * pb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input logic [15:0] a, input logic [15:0] b);
        if (id) begin A1 = a; B1 = b; end
        else begin A0 = a; B0 = b; end
    endtask

    // Single-requester operation; entered and left at posedge+1.
    task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input bit scramble);
        bit got;
        int lat;
        drive(id, a, b);
        if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin got = 1; break; end
        end
        chk("accept_seen", got, 1);
        chk("other_ready_low", id ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("ready_single_pulse", id ? req1_ready : req0_ready, 0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (scramble) drive(id, 16'($urandom), 16'($urandom));
            if (rsp_valid) begin lat = k; break; end
        end
        chk("latency", lat, 17);
        chk("product", C, exp);
        chk("rsp_id", rsp_id, id);
        @(posedge clk); #1;
        chk("rsp_pulse_one_cycle", rsp_valid, 0);
        chk("product_held", C, exp);
        model_last = id;
    endtask

    initial begin
        logic [32:0] exp_q[$];
        logic [32:0] front;
        int nrsp, first_grant, cnt_rsp, seen1, bad1, got0;
        logic [15:0] ra, rb;
        bit rid;
        logic [31:0] pend_exp;

        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("reset_C", C, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b1;
        model_last = 1'b1;

        run_op(0, 16'hFFFE, 16'd14, 32'hFFFF_FFE4, 0);

        run_op(0, 16'h8000, 16'h8000, 32'h4000_0000, 0);
        run_op(1, 16'h8000, 16'h7FFF, 32'hC000_8000, 0);
        run_op(0, 16'h0000, 16'hFFFF, 32'h0000_0000, 0);
        run_op(1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 0);

        // Both requesters valid continuously: grants must alternate, starting with 0.
        A0 = 16'sd3;  B0 = 16'sd5;
        A1 = -16'sd7; B1 = -16'sd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        nrsp = 0; first_grant = -1;
        for (int cyc = 0; cyc < 120 && nrsp < 4; cyc++) begin
            @(negedge clk);
            chk("ready_exclusive", req0_ready & req1_ready, 0);
            if (req0_ready | req1_ready) begin
                chk("grant_alternates", req1_ready, !model_last);
                if (first_grant < 0) first_grant = req1_ready;
                model_last = req1_ready;
                exp_q.push_back({req1_ready, req1_ready ? ref_mul(-16'sd7, -16'sd9) : ref_mul(16'sd3, 16'sd5)});
            end
            @(posedge clk); #1;
            if (rsp_valid) begin
                nrsp++;
                if (exp_q.size() == 0) chk("alt_unexpected_rsp", 1, 0);
                else begin
                    front = exp_q.pop_front();
                    chk("alt_product", C, front[31:0]);
                    chk("alt_id", rsp_id, front[32]);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_rsp_count", nrsp, 4);
        chk("alt_first_grant", first_grant, 0);
        chk("alt_queue_drained", exp_q.size(), 0);

        for (int i = 0; i < 6; i++) begin
            rid = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(rid, ra, rb, ref_mul(ra, rb), 0);
        end

        run_op(1, 16'd100, 16'd200, 32'd20000, 1);

        // Reset five cycles into CALC aborts the operation.
        drive(0, 16'($urandom), 16'($urandom));
        req0_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_abort", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_C", C, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_last = 1'b1;
        cnt_rsp = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt_rsp++;
        end
        chk("abort_no_response", cnt_rsp, 0);
        ra = 16'($urandom); rb = 16'($urandom);
        run_op(0, ra, rb, ref_mul(ra, rb), 0);

        // Short valid pulse on req1 while busy must never be accepted.
        ra = 16'($urandom); rb = 16'($urandom);
        pend_exp = ref_mul(ra, rb);
        drive(0, ra, rb);
        req0_valid = 1'b1;
        @(negedge clk);
        chk("pulse_test_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("pulse_test_busy", busy, 1);
        drive(1, 16'($urandom), 16'($urandom));
        req1_valid = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        seen1 = 0; bad1 = 0; got0 = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req1_ready) seen1++;
            @(posedge clk); #1;
            if (rsp_valid) begin
                if (rsp_id) bad1++;
                else begin
                    got0++;
                    chk("pulse_test_product", C, pend_exp);
                end
            end
        end
        chk("pulse_never_ready", seen1, 0);
        chk("pulse_no_id1_rsp", bad1, 0);
        chk("pulse_one_id0_rsp", got0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
